// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller for the 8-bit program counter.
// Requests an instruction, waits for memory, decodes the 2-bit opcode, holds
// the ALU execute enable for EXEC_CYCLES, then issues one step pulse to the
// counter along with its jump controls.
//
// Ports:
//   CLK, RST          clock (posedge), synchronous active-high reset
//   START             level; leaves IDLE when high
//   INSTR_VALID       memory has INSTR ready (sampled in WAIT only)
//   INSTR[7:0]        instruction word
//   COND              branch flag, sampled in DECODE only
//   STALL             freezes EXEC and ADVANCE
//   FETCH_REQ         high throughout FETCH and WAIT
//   IR[7:0]           latched instruction
//   EXEC_EN           ALU execute enable
//   PC_ADVANCE        one-cycle step pulse to the counter
//   JMP, JMP_OFFSET   jump request/code, valid only with PC_ADVANCE
//   HALTED            in HALT state
//   FAULT             sticky memory-timeout flag
//   RETIRED[15:0]     saturating retired-instruction count
//
// Every output is a flop. Per-state levels (FETCH_REQ, EXEC_EN, HALTED) are
// registered from the next state, so they line up with the state cycle. The
// advance pulse is registered on the edge that leaves ADVANCE with STALL low,
// so it is visible in the first cycle of the following state.

module pc_sequencer #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned WAIT_LIMIT  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        INSTR_VALID,
  input  logic [7:0]  INSTR,
  input  logic        COND,
  input  logic        STALL,
  output logic        FETCH_REQ,
  output logic [7:0]  IR,
  output logic        EXEC_EN,
  output logic        PC_ADVANCE,
  output logic        JMP,
  output logic [1:0]  JMP_OFFSET,
  output logic        HALTED,
  output logic        FAULT,
  output logic [15:0] RETIRED
);

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned WCNT_W  = 8;
  localparam int unsigned ECNT_W  = 4;
  localparam int unsigned RET_W   = 16;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned OP_W    = 2;

  localparam logic [OP_W-1:0]    OP_ALU  = 2'b00;
  localparam logic [OP_W-1:0]    OP_CJMP = 2'b01;
  localparam logic [OP_W-1:0]    OP_UJMP = 2'b10;
  localparam logic [INSTR_W-1:0] HALT_WORD = 8'hFF;
  localparam logic [RET_W-1:0]   RET_MAX   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_ADVANCE,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ECNT_W-1:0]   exec_cnt_q, exec_cnt_d;
  logic                taken_q, taken_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [INSTR_W-1:0]  ir_d;
  logic                fault_d;
  logic [RET_W-1:0]    retired_q, retired_d;
  logic                fetch_req_d;
  logic                exec_en_d;
  logic                pc_adv_d;
  logic                jmp_d;
  logic [OFF_W-1:0]    jmp_off_d;
  logic                halted_d;
  logic [OP_W-1:0]     opcode;

  assign opcode  = IR[7:6];
  assign RETIRED = retired_q;

  // Next-state and next-register values.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    exec_cnt_d = exec_cnt_q;
    taken_d    = taken_q;
    off_d      = off_q;
    ir_d       = IR;
    fault_d    = FAULT;
    retired_d  = retired_q;
    pc_adv_d   = 1'b0;
    jmp_d      = 1'b0;
    jmp_off_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (INSTR_VALID) begin
          ir_d    = INSTR;
          state_d = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          // Counter is about to reach the limit: memory timed out.
          if (wait_cnt_q == WCNT_W'(WAIT_LIMIT - 1)) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_CJMP: taken_d = COND;
          OP_UJMP: taken_d = 1'b1;
          default: taken_d = 1'b0;
        endcase
        // Offset is zeroed for untaken ops so the pulse needs no masking.
        off_d = ((opcode == OP_UJMP) || ((opcode == OP_CJMP) && COND))
                ? IR[1:0] : OFF_W'(0);
        if (opcode == OP_ALU) begin
          exec_cnt_d = ECNT_W'(EXEC_CYCLES);
          state_d    = S_EXEC;
        end else begin
          state_d = S_ADVANCE;
        end
      end

      S_EXEC: begin
        if (!STALL) begin
          if (exec_cnt_q == ECNT_W'(1)) begin
            state_d = S_ADVANCE;
          end else begin
            exec_cnt_d = exec_cnt_q - ECNT_W'(1);
          end
        end
      end

      S_ADVANCE: begin
        if (!STALL) begin
          pc_adv_d  = 1'b1;
          jmp_d     = taken_q;
          jmp_off_d = off_q;
          retired_d = (retired_q == RET_MAX) ? retired_q
                                             : retired_q + RET_W'(1);
          state_d   = (IR == HALT_WORD) ? S_HALT : S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    fetch_req_d = (state_d == S_FETCH) || (state_d == S_WAIT);
    exec_en_d   = (state_d == S_EXEC);
    halted_d    = (state_d == S_HALT);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      exec_cnt_q <= '0;
      taken_q    <= 1'b0;
      off_q      <= '0;
      IR         <= '0;
      FAULT      <= 1'b0;
      retired_q  <= '0;
      FETCH_REQ  <= 1'b0;
      EXEC_EN    <= 1'b0;
      PC_ADVANCE <= 1'b0;
      JMP        <= 1'b0;
      JMP_OFFSET <= '0;
      HALTED     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      exec_cnt_q <= exec_cnt_d;
      taken_q    <= taken_d;
      off_q      <= off_d;
      IR         <= ir_d;
      FAULT      <= fault_d;
      retired_q  <= retired_d;
      FETCH_REQ  <= fetch_req_d;
      EXEC_EN    <= exec_en_d;
      PC_ADVANCE <= pc_adv_d;
      JMP        <= jmp_d;
      JMP_OFFSET <= jmp_off_d;
      HALTED     <= halted_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: per-instruction timeline model with randomized
// instructions, memory delays, stalls and don't-care input noise.

module tb_pc_sequencer;

  localparam int unsigned EXEC_CYCLES = 2;
  localparam int unsigned WAIT_LIMIT  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        instr_valid;
  logic [7:0]  instr;
  logic        cond;
  logic        stall;
  logic        fetch_req;
  logic [7:0]  ir;
  logic        exec_en;
  logic        pc_advance;
  logic        jmp;
  logic [1:0]  jmp_offset;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  int unsigned exp_retired = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .EXEC_CYCLES(EXEC_CYCLES),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .INSTR_VALID(instr_valid),
    .INSTR      (instr),
    .COND       (cond),
    .STALL      (stall),
    .FETCH_REQ  (fetch_req),
    .IR         (ir),
    .EXEC_EN    (exec_en),
    .PC_ADVANCE (pc_advance),
    .JMP        (jmp),
    .JMP_OFFSET (jmp_offset),
    .HALTED     (halted),
    .FAULT      (fault),
    .RETIRED    (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled mid-cycle on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".fetch_req"}, 32'(fetch_req), 0);
    check_eq({tag, ".ir"},        32'(ir), 0);
    check_eq({tag, ".exec_en"},   32'(exec_en), 0);
    check_eq({tag, ".pc_adv"},    32'(pc_advance), 0);
    check_eq({tag, ".jmp"},       32'(jmp), 0);
    check_eq({tag, ".jmp_off"},   32'(jmp_offset), 0);
    check_eq({tag, ".halted"},    32'(halted), 0);
    check_eq({tag, ".fault"},     32'(fault), 0);
    check_eq({tag, ".retired"},   32'(retired), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr = '0; cond = 1'b0; stall = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_retired = 0;
    check_all_zero("reset");
  endtask

  // From IDLE: raise START for one edge; returns in the FETCH cycle.
  task automatic start_from_idle();
    start = 1'b1;
    step();
  endtask

  function automatic bit ref_taken(input logic [7:0] ins, input bit c);
    return (ins[7:6] == 2'b10) || (ins[7:6] == 2'b01 && c);
  endfunction

  // One instruction. Called in its FETCH cycle (t=0). d = WAIT cycles before
  // INSTR_VALID, se = stalled EXEC cycles, sa = stalled ADVANCE cycles.
  // Returns in the cycle showing the advance pulse (t=tp).
  task automatic do_instr(input logic [7:0] ins, input bit c, input int d,
                          input int se, input int sa);
    bit alu, hlt, tk;
    int e_len, tp;
    alu   = (ins[7:6] == 2'b00);
    hlt   = (ins == 8'hFF);
    tk    = ref_taken(ins, c);
    e_len = alu ? int'(EXEC_CYCLES) + se : 0;
    tp    = d + 3 + e_len + sa + 1;
    for (int t = 0; t < tp; t++) begin
      check_eq("fetch_req", 32'(fetch_req), 32'(t <= d + 1));
      check_eq("exec_en", 32'(exec_en), 32'(alu && t >= d + 3 && t < d + 3 + e_len));
      check_eq("halted", 32'(halted), 0);
      if (t > 0) begin
        check_eq("pc_adv_idle", 32'(pc_advance), 0);
        check_eq("jmp_idle", 32'(jmp), 0);
      end
      if (t >= d + 2) check_eq("ir", 32'(ir), 32'(ins));
      start = 1'($urandom);
      instr = 8'($urandom);
      if (t == d + 1) begin
        instr_valid = 1'b1;
        instr       = ins;
      end else if (t >= 1 && t <= d) begin
        instr_valid = 1'b0;
      end else begin
        instr_valid = 1'($urandom);
      end
      cond = (t == d + 2) ? c : 1'($urandom);
      if (t <= d + 2)              stall = 1'($urandom);
      else if (t < d + 3 + e_len)  stall = (t < d + 3 + se);
      else                         stall = (t < d + 3 + e_len + sa);
      step();
    end
    if (exp_retired < 32'hFFFF) exp_retired++;
    check_eq("pc_adv", 32'(pc_advance), 1);
    check_eq("jmp", 32'(jmp), 32'(tk));
    check_eq("jmp_off", 32'(jmp_offset), tk ? 32'(ins[1:0]) : 0);
    check_eq("retired", 32'(retired), exp_retired);
    check_eq("halted_end", 32'(halted), 32'(hlt));
    check_eq("fetch_req_end", 32'(fetch_req), 32'(!hlt));
    check_eq("exec_en_end", 32'(exec_en), 0);
  endtask

  initial begin
    logic [7:0] rins;
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr = '0; cond = 1'b0; stall = 1'b0;

    // Basic function: ALU, conditional jumps both ways, stalled jump.
    do_reset();
    start_from_idle();
    do_instr(8'h00, 1'b0, 0, 0, 0);
    do_instr(8'h42, 1'b1, 0, 0, 0);
    do_instr(8'h42, 1'b0, 0, 0, 0);
    do_instr(8'h83, 1'b0, 0, 0, 3);
    do_instr(8'h01, 1'b1, WAIT_LIMIT - 1, 2, 1);
    do_instr(8'hC1, 1'b1, 3, 0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      rins = 8'($urandom);
      if (rins == 8'hFF) rins = 8'hFE;
      do_instr(rins, 1'($urandom), int'($urandom_range(0, WAIT_LIMIT - 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // HALT instruction retires, then the sequencer stays parked.
    do_instr(8'hFF, 1'b0, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; instr_valid = 1'($urandom); stall = 1'($urandom);
      step();
      check_eq("halt_hold", 32'(halted), 1);
      check_eq("halt_fetch_req", 32'(fetch_req), 0);
      check_eq("halt_pc_adv", 32'(pc_advance), 0);
      check_eq("halt_exec_en", 32'(exec_en), 0);
    end
    do_reset();

    // Memory timeout: FAULT and HALT after WAIT_LIMIT empty WAIT cycles.
    start_from_idle();
    for (int t = 0; t <= int'(WAIT_LIMIT); t++) begin
      check_eq("to_fetch_req", 32'(fetch_req), 1);
      check_eq("to_halted", 32'(halted), 0);
      check_eq("to_fault", 32'(fault), 0);
      instr_valid = (t == 0) ? 1'b1 : 1'b0;
      start = 1'($urandom); stall = 1'($urandom);
      step();
    end
    check_eq("to_halted_end", 32'(halted), 1);
    check_eq("to_fault_end", 32'(fault), 1);
    check_eq("to_fetch_req_end", 32'(fetch_req), 0);
    check_eq("to_retired", 32'(retired), exp_retired);
    for (int k = 0; k < 4; k++) begin
      instr_valid = 1'b1; start = 1'b1;
      step();
      check_eq("to_stay_halted", 32'(halted), 1);
      check_eq("to_stay_fault", 32'(fault), 1);
    end
    do_reset();

    // Reset during EXEC aborts the instruction with no pulse.
    start_from_idle();
    start = 1'b0; instr_valid = 1'b0; stall = 1'b1;
    step();
    instr_valid = 1'b1; instr = 8'h00;
    step();
    instr_valid = 1'b0; stall = 1'b0;
    step();
    check_eq("rx_exec_en", 32'(exec_en), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rx");
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("rx_pc_adv", 32'(pc_advance), 0);
      check_eq("rx_idle", 32'(fetch_req), 0);
    end

    // Saturation: preload the counter just below the ceiling while idle.
    force dut.retired_q = 16'hFFFE;
    step();
    release dut.retired_q;
    exp_retired = 32'hFFFE;
    step();
    check_eq("sat_preload", 32'(retired), exp_retired);
    start_from_idle();
    do_instr(8'h80, 1'b0, 0, 0, 0);
    do_instr(8'h00, 1'b0, 0, 1, 0);
    do_instr(8'h43, 1'b1, 2, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/decode/execute controller for the 8-bit program counter. Requests an instruction, waits for memory, decodes the 2-bit opcode, holds the execute enable for a fixed number of cycles, then issues a single-cycle advance pulse with the jump controls the counter consumes. It sits between the counter, instruction memory and the ALU datapath, and is the only driver of the counter's step and jump inputs.

## Interface
- EXEC_CYCLES, 2: cycles EXEC_EN is held for an ALU op (1..15)
- WAIT_LIMIT, 8: max cycles in WAIT before fault (1..255)
- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- START  in  1  level; leaves IDLE when high
- INSTR_VALID  in  1  memory has INSTR ready
- INSTR  in  8  instruction word, sampled when INSTR_VALID
- COND  in  1  branch flag from datapath, sampled in DECODE
- STALL  in  1  freezes EXEC and ADVANCE
- FETCH_REQ  out  1  high throughout FETCH and WAIT
- IR  out  8  latched instruction
- EXEC_EN  out  1  ALU execute enable
- PC_ADVANCE  out  1  one-cycle step pulse to counter
- JMP  out  1  jump request, valid only with PC_ADVANCE
- JMP_OFFSET  out  2  jump code, valid only with PC_ADVANCE
- HALTED  out  1  in HALT state
- FAULT  out  1  sticky memory-timeout flag
- RETIRED  out  16  retired-instruction count, saturating

## Operation
- Opcode IR[7:6]: 00 ALU; 01 conditional jump (taken iff COND); 10 unconditional jump; 11 with IR[5:0]=6'h3F is HALT, any other 11 is NOP.
- Jump code = IR[1:0]. Counter semantics: 00 next, 01 skip one, 10 back one, 11 repeat same address.
- States: IDLE, FETCH, WAIT, DECODE, EXEC, ADVANCE, HALT.
- IDLE -> FETCH when START=1.
- FETCH (1 cycle) -> WAIT; wait counter cleared.
- WAIT: if INSTR_VALID, latch IR <= INSTR and go to DECODE; otherwise increment the wait counter; when it reaches WAIT_LIMIT, set FAULT and go to HALT.
- DECODE (1 cycle): ALU -> EXEC with exec counter = EXEC_CYCLES; any other opcode -> ADVANCE. Jump-taken decision and JMP_OFFSET are registered here.
- EXEC: EXEC_EN=1; counter decrements only when STALL=0; leaves to ADVANCE the cycle after the counter reaches 1 with STALL=0.
- ADVANCE: if STALL=1, hold with all outputs low. Otherwise PC_ADVANCE=1 for exactly one cycle, with JMP=taken and JMP_OFFSET=IR[1:0] (both 0 when not taken). RETIRED increments. Next state is HALT for a HALT op, else FETCH.
- HALT: HALTED=1; FETCH_REQ, EXEC_EN and PC_ADVANCE stay 0. Only RST exits.
- RETIRED saturates at 16'hFFFF. A HALT instruction counts as retired.
- START is ignored outside IDLE. COND is ignored outside DECODE.

## Timing
- Reset (synchronous, takes priority over all): state=IDLE; IR=0, EXEC_EN=0, PC_ADVANCE=0, JMP=0, JMP_OFFSET=0, FETCH_REQ=0, HALTED=0, FAULT=0, RETIRED=0, counters=0.
- RST asserted mid-instruction aborts it with no PC_ADVANCE pulse; RETIRED is not incremented.
- All outputs are registered from the state and latched fields; none is combinational from inputs.
- Unstalled latency, memory ready on the first WAIT cycle:
  - non-ALU op: FETCH(1) + WAIT(1) + DECODE(1) + ADVANCE(1) = 4 cycles per instruction.
  - ALU op: 4 + EXEC_CYCLES cycles.
- PC_ADVANCE is never high on two consecutive cycles.
- Because JMP is only valid alongside PC_ADVANCE, the counter never sees a jump without a step.
- FETCH_REQ deasserts the cycle after INSTR_VALID is sampled.
- INSTR_VALID during FETCH is ignored.
- STALL during FETCH, WAIT or DECODE has no effect.

## Test plan
- Reset, START=1, INSTR=8'h00 (ALU) valid on the first WAIT cycle, EXEC_CYCLES=2 -> EXEC_EN high 2 cycles, PC_ADVANCE on cycle 6 with JMP=0, RETIRED=1.
- INSTR=8'h42 with COND=1 -> JMP=1, JMP_OFFSET=2'b10. Same instruction with COND=0 -> JMP=0, JMP_OFFSET=0. Both take 4 cycles.
- INSTR=8'h83 (unconditional jump), STALL held 3 cycles in ADVANCE -> PC_ADVANCE delayed exactly 3 cycles, single pulse, JMP_OFFSET=2'b11.
- INSTR_VALID held low, WAIT_LIMIT=8 -> FAULT=1 and HALTED=1 after 8 WAIT cycles; RETIRED unchanged; stays halted until RST.
- INSTR=8'hFF -> one PC_ADVANCE, then HALTED=1, FETCH_REQ=0 permanently; RST returns all outputs to 0.
- RST pulsed during EXEC -> next cycle IDLE, all outputs 0, no PC_ADVANCE; preload RETIRED to 16'hFFFF, retire one more -> stays 16'hFFFF.
